// File: rtl/pedestrian_hit_detector_pkg.sv
// Shared types and helpers for the pedestrian hit detector and box overlap logic.
package ped_hit_pkg;

    typedef logic [10:0] coord_t;

    typedef enum logic [1:0] {
        ARMED,
        HIT,
        COOLDOWN
    } hit_state_t;

    localparam int unsigned TIMER_W = 10;

    typedef logic [TIMER_W-1:0] timer_t;

    // Widened to 12-bit signed so the difference of two 11-bit coordinates cannot wrap.
    function automatic logic [11:0] abs_diff(input coord_t a, input coord_t b);
        logic signed [11:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[11] ? 12'(-d) : 12'(d);
    endfunction

endpackage

// File: rtl/pedestrian_hit_detector_if.sv
// Bus between the game logic (master) and one pedestrian hit detector (slave).
interface pedestrian_hit_detector_if
    import ped_hit_pkg::*;
#(
    parameter int unsigned COUNT_W = 8
) ();

    logic               enable;
    coord_t             carX;
    coord_t             carY;
    coord_t             carS;
    coord_t             manX;
    coord_t             manY;
    coord_t             manS;
    logic               hit_man;
    logic               respawn;
    logic [COUNT_W-1:0] hit_count;
    logic               flash;

    modport master (
        output enable, carX, carY, carS, manX, manY, manS,
        input  hit_man, respawn, hit_count, flash
    );

    modport slave (
        input  enable, carX, carY, carS, manX, manY, manS,
        output hit_man, respawn, hit_count, flash
    );

endinterface

// File: rtl/pedestrian_hit_detector_box_overlap.sv
// Combinational overlap test of two centre/half-size boxes; touching edges do not overlap.
module box_overlap
    import ped_hit_pkg::*;
(
    input  coord_t a_x,
    input  coord_t a_y,
    input  coord_t a_s,
    input  coord_t b_x,
    input  coord_t b_y,
    input  coord_t b_s,
    output logic   overlap
);

    logic [11:0] dx;
    logic [11:0] dy;
    logic [11:0] size_sum;

    assign dx       = abs_diff(a_x, b_x);
    assign dy       = abs_diff(a_y, b_y);
    assign size_sum = {1'b0, a_s} + {1'b0, b_s};
    assign overlap  = (dx < size_sum) && (dy < size_sum);

endmodule

// File: rtl/pedestrian_hit_detector.sv
// Per-car pedestrian hit sequencer: ARMED -> HIT (hold) -> COOLDOWN -> ARMED.
// Optional sprite blink divider enabled by defining PED_HIT_FLASH_EN.
module pedestrian_hit_detector
    import ped_hit_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES     = 60,
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned COUNT_W         = 8,
    parameter int unsigned FLASH_PERIOD    = 8
) (
    input logic                       frame_clk,
    input logic                       Reset,
    pedestrian_hit_detector_if.slave  bus
);

    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 1023) begin : g_bad_hold
        $error("HOLD_FRAMES must be in 1..1023");
    end
    if (COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 1023) begin : g_bad_cool
        $error("COOLDOWN_FRAMES must be in 1..1023");
    end
    if (FLASH_PERIOD < 1 || FLASH_PERIOD > 255) begin : g_bad_flash
        $error("FLASH_PERIOD must be in 1..255");
    end

    hit_state_t         state_q, state_d;
    timer_t             timer_q, timer_d;
    logic [COUNT_W-1:0] hit_count_q, hit_count_d;
    logic               hit_man_q, respawn_q, respawn_d;
    logic               flash_q;
    logic               overlap;

    box_overlap u_overlap (
        .a_x     (bus.carX),
        .a_y     (bus.carY),
        .a_s     (bus.carS),
        .b_x     (bus.manX),
        .b_y     (bus.manY),
        .b_s     (bus.manS),
        .overlap (overlap)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ARMED;
            timer_q     <= '0;
            hit_count_q <= '0;
            hit_man_q   <= 1'b0;
            respawn_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            hit_count_q <= hit_count_d;
            hit_man_q   <= (state_d == HIT);
            respawn_q   <= respawn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARMED:    if (bus.enable && overlap) state_d = HIT;
            HIT:      if (timer_q == '0)         state_d = COOLDOWN;
            COOLDOWN: if (timer_q == '0)         state_d = ARMED;
            default:                             state_d = ARMED;
        endcase
    end

    always_comb begin
        timer_d     = timer_q;
        hit_count_d = hit_count_q;
        respawn_d   = 1'b0;
        unique case (state_q)
            ARMED: begin
                if (state_d == HIT) begin
                    timer_d     = timer_t'(HOLD_FRAMES - 1);
                    hit_count_d = (&hit_count_q) ? hit_count_q : hit_count_q + 1'b1;
                end
            end
            HIT: begin
                if (state_d == COOLDOWN) begin
                    timer_d   = timer_t'(COOLDOWN_FRAMES - 1);
                    respawn_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            COOLDOWN: begin
                if (state_d == COOLDOWN) timer_d = timer_q - 1'b1;
            end
            default: timer_d = '0;
        endcase
    end

`ifdef PED_HIT_FLASH_EN
    logic [7:0] div_q, div_d;
    logic       flash_d;

    // Divider restarts on HIT entry so every hit blinks with the same phase.
    always_comb begin
        div_d   = '0;
        flash_d = 1'b0;
        if (state_d == HIT) begin
            if (state_q != HIT) begin
                flash_d = 1'b1;
            end else if (div_q == 8'(FLASH_PERIOD - 1)) begin
                flash_d = ~flash_q;
            end else begin
                div_d   = div_q + 1'b1;
                flash_d = flash_q;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            div_q   <= '0;
            flash_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            flash_q <= flash_d;
        end
    end
`else
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) flash_q <= 1'b0;
        else       flash_q <= (state_d == HIT);
    end
`endif

    assign bus.hit_man   = hit_man_q;
    assign bus.respawn   = respawn_q;
    assign bus.hit_count = hit_count_q;
    assign bus.flash     = flash_q;

endmodule

// File: tb/tb_pedestrian_hit_detector.sv
// Scoreboard bench: a frame-level model predicts both detector instances every frame.
module tb_pedestrian_hit_detector;
    import ped_hit_pkg::*;

    localparam int HOLD_A = 60;
    localparam int COOL_A = 30;
    localparam int HOLD_B = 3;
    localparam int COOL_B = 2;
    localparam int FP     = 8;

    typedef struct packed {
        logic [10:0] a;
        logic [4:0]  b;
    } exp_t;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b0;

    always #5 frame_clk = ~frame_clk;

    pedestrian_hit_detector_if #(.COUNT_W(8)) bus_a ();
    pedestrian_hit_detector_if #(.COUNT_W(2)) bus_b ();

    pedestrian_hit_detector #(
        .HOLD_FRAMES(HOLD_A), .COOLDOWN_FRAMES(COOL_A), .COUNT_W(8), .FLASH_PERIOD(FP)
    ) dut_a (
        .frame_clk(frame_clk), .Reset(Reset), .bus(bus_a.slave)
    );

    pedestrian_hit_detector #(
        .HOLD_FRAMES(HOLD_B), .COOLDOWN_FRAMES(COOL_B), .COUNT_W(2), .FLASH_PERIOD(FP)
    ) dut_b (
        .frame_clk(frame_clk), .Reset(Reset), .bus(bus_b.slave)
    );

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bit m_hit[2], m_resp[2];
    int m_hold[2], m_cool[2], m_cnt[2], m_age[2];

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit ovl_model(input int cx, cy, cs, mx, my, ms);
        return (abs_i(cx - mx) < cs + ms) && (abs_i(cy - my) < cs + ms);
    endfunction

    function automatic bit flash_model(input int i);
`ifdef PED_HIT_FLASH_EN
        return m_hit[i] && ((m_age[i] / FP) % 2 == 0);
`else
        return m_hit[i];
`endif
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.a = {bus_a.hit_man, bus_a.respawn, bus_a.flash, bus_a.hit_count};
        o.b = {bus_b.hit_man, bus_b.respawn, bus_b.flash, bus_b.hit_count};
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hit[i] = 0; m_resp[i] = 0; m_hold[i] = 0;
            m_cool[i] = 0; m_cnt[i] = 0; m_age[i] = 0;
        end
        sb.delete();
    endtask

    task automatic model_step(input int i, input bit en, input bit ovl);
        int hold_p = (i == 0) ? HOLD_A : HOLD_B;
        int cool_p = (i == 0) ? COOL_A : COOL_B;
        int max_c  = (i == 0) ? 255 : 3;
        m_resp[i] = 0;
        if (m_hit[i]) begin
            m_hold[i]--;
            m_age[i]++;
            if (m_hold[i] == 0) begin
                m_hit[i] = 0; m_resp[i] = 1; m_cool[i] = cool_p;
            end
        end else if (m_cool[i] > 0) begin
            m_cool[i]--;
        end else if (en && ovl) begin
            m_hit[i] = 1; m_hold[i] = hold_p; m_age[i] = 0;
            if (m_cnt[i] < max_c) m_cnt[i]++;
        end
    endtask

    // Drives one frame's inputs, predicts the post-edge outputs, then steps past the edge.
    task automatic drive_frame(input bit en, input int cx, cy, cs, mx, my, ms);
        exp_t e;
        bit   ovl;
        bus_a.enable = en; bus_b.enable = en;
        bus_a.carX = 11'(cx); bus_a.carY = 11'(cy); bus_a.carS = 11'(cs);
        bus_a.manX = 11'(mx); bus_a.manY = 11'(my); bus_a.manS = 11'(ms);
        bus_b.carX = 11'(cx); bus_b.carY = 11'(cy); bus_b.carS = 11'(cs);
        bus_b.manX = 11'(mx); bus_b.manY = 11'(my); bus_b.manS = 11'(ms);
        ovl = ovl_model(cx, cy, cs, mx, my, ms);
        for (int i = 0; i < 2; i++) model_step(i, en, ovl);
        e.a = {m_hit[0], m_resp[0], flash_model(0), 8'(m_cnt[0])};
        e.b = {m_hit[1], m_resp[1], flash_model(1), 2'(m_cnt[1])};
        sb.push_back(e);
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        #2;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        drive_frame(1'b0, 400, 360, 8, 100, 360, 8);
        sb.delete();
        #1 Reset = 1'b1;
        @(posedge frame_clk);
        #1;
        total++;
        if ({bus_a.hit_man, bus_a.respawn, bus_a.flash, bus_a.hit_count} !== 11'h0) begin
            bad++;
            $display("FAIL reset_a got=%h want=000", observe().a);
        end
        total++;
        if (observe().b !== 5'h0) begin
            bad++;
            $display("FAIL reset_b got=%h want=00", observe().b);
        end
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        exp_t e, g;
        int   hi = 0, pulses = 0;
        do_reset();
        for (int f = 1; f <= 100; f++) begin
            if (f == 1) drive_frame(1'b1, 110, 360, 8, 100, 360, 8);
            else        drive_frame(1'b1, 400, 360, 8, 100, 360, 8);
            e = sb.pop_front(); g = observe();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL sb_basic frame=%0d got=%h want=%h", f, g, e);
            end
            if (f == 1) begin
                total++;
                if (bus_a.hit_man !== 1'b1 || bus_a.hit_count !== 8'd1) begin
                    bad++;
                    $display("FAIL basic_first hit=%b cnt=%0d want hit=1 cnt=1",
                             bus_a.hit_man, bus_a.hit_count);
                end
            end
            hi     += int'(bus_a.hit_man);
            pulses += int'(bus_a.respawn);
        end
        total++;
        if (hi != HOLD_A) begin bad++; $display("FAIL basic_hold got=%0d want=%0d", hi, HOLD_A); end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL basic_respawn got=%0d want=1", pulses); end
    endtask

    task automatic test_touch();
        exp_t e, g;
        do_reset();
        for (int f = 1; f <= 6; f++) begin
            drive_frame(1'b1, (f < 6) ? 116 : 115, 360, 8, 100, 360, 8);
            e = sb.pop_front(); g = observe();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL sb_touch frame=%0d got=%h want=%h", f, g, e);
            end
            total++;
            if (bus_a.hit_man !== (f == 6)) begin
                bad++;
                $display("FAIL touch_edge frame=%0d got=%b want=%b", f, bus_a.hit_man, f == 6);
            end
        end
    endtask

    task automatic test_cooldown();
        exp_t e, g;
        bit   prev = 0;
        int   fall1 = -1, rise2 = -1, rises = 0;
        do_reset();
        for (int f = 1; f <= 160; f++) begin
            drive_frame(1'b1, 110, 360, 8, 100, 360, 8);
            e = sb.pop_front(); g = observe();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL sb_cool frame=%0d got=%h want=%h", f, g, e);
            end
            if (bus_a.hit_man && !prev) begin
                rises++;
                if (rises == 2) rise2 = f;
            end
            if (!bus_a.hit_man && prev && fall1 < 0) fall1 = f;
            prev = bus_a.hit_man;
        end
        total++;
        if (rise2 - fall1 != COOL_A + 1) begin
            bad++;
            $display("FAIL cool_gap got=%0d want=%0d", rise2 - fall1, COOL_A + 1);
        end
        total++;
        if (bus_a.hit_count !== 8'd2) begin
            bad++;
            $display("FAIL cool_count got=%0d want=2", bus_a.hit_count);
        end
        total++;
        if (bus_b.hit_count !== 2'd3) begin
            bad++;
            $display("FAIL sat_count got=%0d want=3", bus_b.hit_count);
        end
    endtask

    task automatic test_enable();
        exp_t e, g;
        int   hi = 0;
        do_reset();
        for (int f = 1; f <= 176; f++) begin
            drive_frame(f == 101, 110, 360, 8, 100, 360, 8);
            e = sb.pop_front(); g = observe();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL sb_enable frame=%0d got=%h want=%h", f, g, e);
            end
            if (f == 100) begin
                total++;
                if (bus_a.hit_count !== 8'd0 || bus_a.hit_man !== 1'b0) begin
                    bad++;
                    $display("FAIL enable_gate cnt=%0d hit=%b want cnt=0 hit=0",
                             bus_a.hit_count, bus_a.hit_man);
                end
            end
            if (f > 100) hi += int'(bus_a.hit_man);
        end
        total++;
        if (hi != HOLD_A) begin bad++; $display("FAIL enable_hold got=%0d want=%0d", hi, HOLD_A); end
    endtask

    task automatic test_reset_mid_hit();
        exp_t e, g;
        int   pulses = 0;
        do_reset();
        for (int f = 1; f <= 20; f++) begin
            drive_frame(1'b1, 110, 360, 8, 100, 360, 8);
            e = sb.pop_front(); g = observe();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL sb_midhit frame=%0d got=%h want=%h", f, g, e);
            end
        end
        Reset = 1'b1;
        #1;
        total++;
        if (bus_a.hit_man !== 1'b0 || bus_a.hit_count !== 8'd0 || bus_a.respawn !== 1'b0) begin
            bad++;
            $display("FAIL midhit_async hit=%b cnt=%0d resp=%b want 0/0/0",
                     bus_a.hit_man, bus_a.hit_count, bus_a.respawn);
        end
        model_reset();
        #1 Reset = 1'b0;
        for (int f = 1; f <= 70; f++) begin
            drive_frame(1'b1, 400, 360, 8, 100, 360, 8);
            e = sb.pop_front(); g = observe();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL sb_postrst frame=%0d got=%h want=%h", f, g, e);
            end
            pulses += int'(bus_a.respawn);
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL midhit_respawn got=%0d want=0", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_touch();
        test_cooldown();
        test_enable();
        test_reset_mid_hit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
